// File: rtl/mayo_axi_burst_ram.sv
`default_nettype none
// ============================================================================
// Module   : mayo_axi_burst_ram
// Brief    : AXI4 slave RAM with FIXED/INCR/WRAP bursts, independent read and
//            write channels, byte strobes and SLVERR on illegal commands.
// Revision : 1.0 - initial release
// ============================================================================
module mayo_axi_burst_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_WORDS  = 256
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [ID_WIDTH-1:0]     AWID,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [7:0]              AWLEN,
  input  logic [1:0]              AWBURST,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [ID_WIDTH-1:0]     BID,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ID_WIDTH-1:0]     ARID,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [7:0]              ARLEN,
  input  logic [1:0]              ARBURST,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [ID_WIDTH-1:0]     RID,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RLAST,
  output logic                    RVALID,
  input  logic                    RREADY
);

  localparam int c_STRB_W    = DATA_WIDTH / 8;
  localparam int c_BYTE_BITS = $clog2(c_STRB_W);
  localparam int c_MEM_AW    = $clog2(MEM_WORDS);
  localparam int c_IDX_HI    = c_MEM_AW + c_BYTE_BITS;

  localparam logic [1:0] c_BURST_FIXED = 2'b00;
  localparam logic [1:0] c_BURST_WRAP  = 2'b10;
  localparam logic [1:0] c_BURST_RSVD  = 2'b11;
  localparam logic [1:0] c_RESP_OKAY   = 2'b00;
  localparam logic [1:0] c_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];

  // Next word address of a burst; WRAP keeps the bits above the wrap mask.
  function automatic logic [c_MEM_AW-1:0] f_next_addr(
    input logic [c_MEM_AW-1:0] addr,
    input logic [7:0]          len,
    input logic [1:0]          burst
  );
    logic [c_MEM_AW-1:0] mask;
    logic [c_MEM_AW-1:0] inc;
    logic [c_MEM_AW-1:0] nxt;
    mask = c_MEM_AW'(len);
    inc  = addr + c_MEM_AW'(1);
    case (burst)
      c_BURST_FIXED: nxt = addr;
      c_BURST_WRAP:  nxt = (addr & ~mask) | (inc & mask);
      default:       nxt = inc;
    endcase
    return nxt;
  endfunction

  function automatic logic f_cmd_err(
    input logic       oor,
    input logic [7:0] len,
    input logic [1:0] burst
  );
    logic bad_wrap;
    bad_wrap = (burst == c_BURST_WRAP) &&
               !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
    return oor || (burst == c_BURST_RSVD) || bad_wrap;
  endfunction

  logic                w_aw_oor;
  logic                w_ar_oor;
  logic [c_MEM_AW-1:0] w_aw_word;
  logic [c_MEM_AW-1:0] w_ar_word;
  logic                w_unused_ok;

  assign w_aw_word   = AWADDR[c_IDX_HI-1:c_BYTE_BITS];
  assign w_ar_word   = ARADDR[c_IDX_HI-1:c_BYTE_BITS];
  assign w_unused_ok = ^{AWADDR[c_BYTE_BITS-1:0], ARADDR[c_BYTE_BITS-1:0]};

  // Any address bit above the memory index marks the start word out of range.
  generate
    if (ADDR_WIDTH > c_IDX_HI) begin : g_range_chk
      assign w_aw_oor = |AWADDR[ADDR_WIDTH-1:c_IDX_HI];
      assign w_ar_oor = |ARADDR[ADDR_WIDTH-1:c_IDX_HI];
    end else begin : g_range_full
      assign w_aw_oor = 1'b0;
      assign w_ar_oor = 1'b0;
    end
  endgenerate

  // ---------------------------------------------------------------- write
  w_state_t            r_wstate;
  w_state_t            w_wstate_nxt;
  logic [ID_WIDTH-1:0] r_wid;
  logic [c_MEM_AW-1:0] r_waddr;
  logic [7:0]          r_wlen;
  logic [1:0]          r_wburst;
  logic [7:0]          r_wcnt;
  logic                r_werr;
  logic                r_wlast_err;
  logic [1:0]          r_bresp;
  logic                w_aw_hs;
  logic                w_w_hs;
  logic                w_w_final;
  logic                w_wlast_bad;

  assign w_aw_hs     = AWVALID && AWREADY;
  assign w_w_hs      = WVALID && WREADY;
  assign w_w_final   = (r_wcnt == r_wlen);
  assign w_wlast_bad = (WLAST != w_w_final);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_wstate <= W_IDLE;
    else        r_wstate <= w_wstate_nxt;
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    AWREADY      = 1'b0;
    WREADY       = 1'b0;
    BVALID       = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        AWREADY = !ARESET;
        if (AWVALID && !ARESET) w_wstate_nxt = W_DATA;
      end
      W_DATA: begin
        WREADY = 1'b1;
        if (WVALID && w_w_final) w_wstate_nxt = W_RESP;
      end
      W_RESP: begin
        BVALID = 1'b1;
        if (BREADY) w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_wid       <= '0;
      r_waddr     <= '0;
      r_wlen      <= '0;
      r_wburst    <= '0;
      r_wcnt      <= '0;
      r_werr      <= 1'b0;
      r_wlast_err <= 1'b0;
      r_bresp     <= c_RESP_OKAY;
    end else begin
      if (w_aw_hs) begin
        r_wid       <= AWID;
        r_waddr     <= w_aw_word;
        r_wlen      <= AWLEN;
        r_wburst    <= AWBURST;
        r_wcnt      <= '0;
        r_werr      <= f_cmd_err(w_aw_oor, AWLEN, AWBURST);
        r_wlast_err <= 1'b0;
      end
      if (w_w_hs) begin
        r_wcnt  <= r_wcnt + 8'd1;
        r_waddr <= f_next_addr(r_waddr, r_wlen, r_wburst);
        if (w_wlast_bad) r_wlast_err <= 1'b1;
        if (w_w_final)
          r_bresp <= (r_werr || r_wlast_err || w_wlast_bad) ? c_RESP_SLVERR : c_RESP_OKAY;
      end
    end
  end

  assign BID   = r_wid;
  assign BRESP = r_bresp;

  // Storage is deliberately outside the reset domain so a reset keeps contents.
  always_ff @(posedge ACLK) begin
    if (w_w_hs && !r_werr) begin
      for (int i = 0; i < c_STRB_W; i++) begin
        if (WSTRB[i]) r_mem[r_waddr][8*i +: 8] <= WDATA[8*i +: 8];
      end
    end
  end

  // ----------------------------------------------------------------- read
  r_state_t              r_rstate;
  r_state_t              w_rstate_nxt;
  logic [ID_WIDTH-1:0]   r_rid;
  logic [c_MEM_AW-1:0]   r_raddr;
  logic [7:0]            r_rlen;
  logic [1:0]            r_rburst;
  logic [7:0]            r_rcnt;
  logic                  r_rerr;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;
  logic                  r_rlast;
  logic                  w_ar_hs;
  logic                  w_r_hs;
  logic                  w_ar_err;

  assign w_ar_hs  = ARVALID && ARREADY;
  assign w_r_hs   = RVALID && RREADY;
  assign w_ar_err = f_cmd_err(w_ar_oor, ARLEN, ARBURST);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_rstate <= R_IDLE;
    else        r_rstate <= w_rstate_nxt;
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    ARREADY      = 1'b0;
    RVALID       = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        ARREADY = !ARESET;
        if (ARVALID && !ARESET) w_rstate_nxt = R_DATA;
      end
      R_DATA: begin
        RVALID = 1'b1;
        if (RREADY && r_rlast) w_rstate_nxt = R_IDLE;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // The beat register only advances on a handshake, so a stall holds it.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_rid    <= '0;
      r_raddr  <= '0;
      r_rlen   <= '0;
      r_rburst <= '0;
      r_rcnt   <= '0;
      r_rerr   <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= c_RESP_OKAY;
      r_rlast  <= 1'b0;
    end else if (w_ar_hs) begin
      r_rid    <= ARID;
      r_rlen   <= ARLEN;
      r_rburst <= ARBURST;
      r_rcnt   <= '0;
      r_rerr   <= w_ar_err;
      r_rresp  <= w_ar_err ? c_RESP_SLVERR : c_RESP_OKAY;
      r_rlast  <= (ARLEN == 8'd0);
      r_rdata  <= w_ar_err ? '0 : r_mem[w_ar_word];
      r_raddr  <= f_next_addr(w_ar_word, ARLEN, ARBURST);
    end else if (w_r_hs) begin
      if (r_rlast) begin
        r_rlast <= 1'b0;
      end else begin
        r_rcnt  <= r_rcnt + 8'd1;
        r_rlast <= ((r_rcnt + 8'd1) == r_rlen);
        r_rdata <= r_rerr ? '0 : r_mem[r_raddr];
        r_raddr <= f_next_addr(r_raddr, r_rlen, r_rburst);
      end
    end
  end

  assign RID   = r_rid;
  assign RDATA = r_rdata;
  assign RRESP = r_rresp;
  assign RLAST = r_rlast;

endmodule
`default_nettype wire

// File: doc/mayo_axi_burst_ram.md
MAYO_AXI_BURST_RAM -- requirements
Module: mayo_axi_burst_ram

Interface
REQ-001 DATA_WIDTH, 32, data bus width in bits; one of 32, 64, 128.
REQ-002 ADDR_WIDTH, 16, byte address width.
REQ-003 ID_WIDTH, 4, transaction ID width.
REQ-004 MEM_WORDS, 256, memory depth in DATA_WIDTH words; power of two.
REQ-005 ACLK  in  1  single clock; all logic on rising edge.
REQ-006 ARESET  in  1  asynchronous, active-high reset.
REQ-007 AWID  in  ID_WIDTH  write ID.
REQ-008 AWADDR  in  ADDR_WIDTH  write start byte address.
REQ-009 AWLEN  in  8  write beats minus one.
REQ-010 AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
REQ-011 AWVALID  in  1  write address valid.
REQ-012 AWREADY  out  1  write address ready.
REQ-013 WDATA  in  DATA_WIDTH  write data.
REQ-014 WSTRB  in  DATA_WIDTH/8  byte enables.
REQ-015 WLAST  in  1  last write beat.
REQ-016 WVALID  in  1  write data valid.
REQ-017 WREADY  out  1  write data ready.
REQ-018 BID  out  ID_WIDTH  echoed AWID.
REQ-019 BRESP  out  2  00 OKAY, 10 SLVERR.
REQ-020 BVALID  out  1  write response valid.
REQ-021 BREADY  in  1  write response ready.
REQ-022 ARID  in  ID_WIDTH  read ID.
REQ-023 ARADDR  in  ADDR_WIDTH  read start byte address.
REQ-024 ARLEN  in  8  read beats minus one.
REQ-025 ARBURST  in  2  encoding as AWBURST.
REQ-026 ARVALID  in  1  read address valid.
REQ-027 ARREADY  out  1  read address ready.
REQ-028 RID  out  ID_WIDTH  echoed ARID.
REQ-029 RDATA  out  DATA_WIDTH  read data.
REQ-030 RRESP  out  2  00 OKAY, 10 SLVERR.
REQ-031 RLAST  out  1  last read beat.
REQ-032 RVALID  out  1  read data valid.
REQ-033 RREADY  in  1  read data ready.

Function
REQ-034 Beat size is always full DATA_WIDTH; word index = addr >> log2(DATA_WIDTH/8), low bits ignored.
REQ-035 Write FSM W_IDLE->W_DATA->W_RESP->W_IDLE: AWREADY=1 only in W_IDLE, AW handshake latches ID/addr/len/burst; WREADY=1 only in W_DATA; beat AWLEN accepted -> W_RESP with BVALID=1 next cycle, held with BID/BRESP stable until BREADY.
REQ-036 Each accepted W beat updates only bytes with WSTRB set; WSTRB=0 beat writes nothing.
REQ-037 Address step: FIXED constant; INCR +1 word per beat, wrapping modulo MEM_WORDS; WRAP aligned to (len+1) words, wrap-around at that boundary.
REQ-038 SLVERR (no memory write; read beats return 0) when: start word >= MEM_WORDS, burst=11, WRAP with len not in {1,3,7,15}; all len+1 beats still transferred.
REQ-039 WLAST mismatch (asserted before beat AWLEN or absent on it): burst ends on count, data written, BRESP=SLVERR.
REQ-040 Read FSM R_IDLE->R_DATA->R_IDLE: ARREADY=1 only in R_IDLE; first RVALID exactly 1 cycle after AR handshake; with RREADY held high one beat per cycle; RLAST=1 only on beat ARLEN; return to R_IDLE after that handshake.
REQ-041 RVALID&&!RREADY: RDATA/RID/RRESP/RLAST held stable; no beat dropped or repeated.
REQ-042 Read and write paths independent and concurrent; same-cycle read and write to one word returns pre-write data.

Reset
REQ-043 ARESET asserted (any time, including mid-burst): FSMs to idle, AWREADY/ARREADY/WREADY/BVALID/RVALID/RLAST=0, BID/RID/BRESP/RRESP/RDATA=0 immediately; memory contents unchanged.
REQ-044 First cycle after ARESET deasserts: AWREADY=1, ARREADY=1.

Verification
REQ-045 INCR len=7 write 1..8 at 0x0, read back -> RDATA 1..8, RLAST on 8th beat, BRESP=RRESP=00.
REQ-046 DATA_WIDTH=32, WRAP len=3 at 0x08, data A,B,C,D -> words 2,3,0,1 hold A,B,C,D.
REQ-047 Word holds 0x11223344, write 0xAABBCCDD WSTRB=0011 -> read 0x1122CCDD.
REQ-048 ARADDR word 300 with MEM_WORDS=256, len=3 -> 4 beats RRESP=10, RDATA=0, RLAST on 4th.
REQ-049 RREADY low 3 cycles at beat 2 of 8 -> RDATA stable, all 8 values received in order.
REQ-050 ARESET during W beat 3 -> WREADY=0, BVALID never asserted, AWREADY=1 first cycle after release; beats 0-2 retained.
